// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer.
// Operands are stepped LSB-first through a single 1-bit full-adder cell,
// one bit per clock. The running carry is held in a register between steps.
// z, cout and ovf update only when the MSB step completes.

// Shared 1-bit full-adder cell (purely combinational).
module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic carry_c
);

  // Sum and carry-out of a single bit position.
  always_comb begin
    sum_c   = a ^ b ^ cin;
    carry_c = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// Sequencer: IDLE -> RUN (W steps) -> DONE -> IDLE.
module serial_add_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  r_sh;
  logic          c;
  logic [CW-1:0] cnt;

  logic          sum_c;
  logic          carry_c;
  logic [W-1:0]  r_next_c;

  // The one shared adder bit, fed with the current LSBs and running carry.
  serial_add_fa u_fa (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .cin     (c),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  // Result shift register after inserting this step's sum bit at the MSB.
  always_comb begin
    r_next_c = (r_sh >> 1) | {sum_c, {(W-1){1'b0}}};
  end

  // Sequencer state, datapath shift registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert b and seed the carry with op.
            a_sh  <= a;
            b_sh  <= op ? ~b : b;
            r_sh  <= '0;
            c     <= op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          r_sh <= r_next_c;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= carry_c;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // MSB step: carry into the MSB vs. carry out gives signed overflow.
            z     <= r_next_c;
            cout  <= carry_c;
            ovf   <= carry_c ^ c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (W=8): vector table, randomized
// operations against an arithmetic reference model, and multi-cycle corner cases.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] z;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_last;

  serial_add_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ez;
    logic         ec;
    logic         ev;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned carry and signed range check.
  function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] rz, output logic rc, output logic rv);
    int ux, uy, sx, sy, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!o) begin
      rz = W'(ux + uy);
      rc = (ux + uy) > 255;
      sr = sx + sy;
    end else begin
      rz = W'(ux - uy);
      rc = ux >= uy;
      sr = sx - sy;
    end
    rv = (sr > 127) || (sr < -128);
  endfunction

  // Full operation with latency, busy-length, hold and result checks.
  task automatic run_op(input string nm, input logic o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ez,
                        input logic ec, input logic ev);
    int n;
    int nb;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    n = 0;
    nb = 0;
    while (done !== 1'b1 && n < 3 * W) begin
      if (busy === 1'b1) nb++;
      if (n == W / 2) chk({nm, "_z_hold"}, int'(z), int'(exp_last));
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_busy_cycles"}, nb, W);
    chk({nm, "_z"}, int'(z), int'(ez));
    chk({nm, "_cout"}, int'(cout), int'(ec));
    chk({nm, "_ovf"}, int'(ovf), int'(ev));
    exp_last = ez;
    @(posedge clk); #1;
    chk({nm, "_done_fall"}, int'(done), 0);
    chk({nm, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    vec_t vecs[7];
    logic [W-1:0] ez;
    logic ec, ev, o;
    logic [W-1:0] av, bv;
    int dc0;
    int n;

    vecs[0] = '{1'b0, 8'h2D, 8'h14, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    exp_last = '0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_z", int'(z), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Idle with start low: nothing moves.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_z", int'(z), 0);
    end

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].ez, vecs[i].ec, vecs[i].ev);

    // Re-pulse of start during RUN is ignored.
    dc0 = done_cnt;
    @(negedge clk);
    op = 1'b0; a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3 * W) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_done_seen", int'(done), 1);
    chk("ign_z", int'(z), 8'h30);
    chk("ign_cout", int'(cout), 0);
    chk("ign_ovf", int'(ovf), 0);
    exp_last = 8'h30;
    repeat (W + 4) @(posedge clk);
    #1;
    chk("ign_single_done", done_cnt - dc0, 1);
    chk("ign_busy_after", int'(busy), 0);

    // Reset mid-RUN aborts without a result or done.
    run_op("pre_rst", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    dc0 = done_cnt;
    @(negedge clk);
    op = 1'b0; a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_z", int'(z), 0);
    chk("abort_cout", int'(cout), 0);
    chk("abort_ovf", int'(ovf), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_last = '0;
    repeat (W + 4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_z_stays", int'(z), 0);
    chk("abort_idle", int'(busy), 0);
    run_op("post_rst", 1'b0, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      o  = 1'($urandom_range(0, 1));
      av = W'($urandom);
      bv = W'($urandom);
      model(o, av, bv, ez, ec, ev);
      run_op($sformatf("rnd%0d", i), o, av, bv, ez, ec, ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
